// File: rtl/async_fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// async_fifo_wr_arb
// Round-robin write-side arbiter that shares one async FIFO write port among
// four requesters. A requester's whole burst is admitted only once the FIFO
// reports enough free space, then it is streamed without interleaving.
//
// Ports
//   wr_clk          write clock; all logic synchronous to it
//   wr_reset_n      asynchronous active-low reset
//   i_req           per-requester burst pending (level)
//   i_req_len       packed burst lengths, [i*LW +: LW] for requester i
//   i_req_data      packed current word per requester, [i*W +: W]
//   o_gnt           one-hot, high for the whole active burst
//   o_data_ack      word consumed this cycle (requester advances on this edge)
//   o_burst_done    one-cycle pulse with the last word of a burst
//   o_req_err       one-cycle pulse when a request has an illegal length
//   o_fifo_wr_en    FIFO write enable
//   o_fifo_wr_data  FIFO write data (don't-care outside a transfer)
//   i_fifo_free     FIFO total free space
//   i_fifo_full     FIFO full flag
//   o_busy          arbiter not idle
// -----------------------------------------------------------------------------
module async_fifo_wr_arb #(
    parameter int unsigned W  = 8,
    parameter int unsigned DP = 16,
    parameter int unsigned AW = 4,
    parameter int unsigned LW = 5
) (
    input  logic            wr_clk,
    input  logic            wr_reset_n,
    input  logic [3:0]      i_req,
    input  logic [4*LW-1:0] i_req_len,
    input  logic [4*W-1:0]  i_req_data,
    output logic [3:0]      o_gnt,
    output logic [3:0]      o_data_ack,
    output logic [3:0]      o_burst_done,
    output logic [3:0]      o_req_err,
    output logic            o_fifo_wr_en,
    output logic [W-1:0]    o_fifo_wr_data,
    input  logic [AW:0]     i_fifo_free,
    input  logic            i_fifo_full,
    output logic            o_busy
);

    // Common width for the free-space vs. length comparison.
    localparam int unsigned CW = (AW + 1 > LW) ? AW + 1 : LW;

    typedef enum logic [1:0] {StIdle, StWait, StXfer} state_e;

    state_e          r_state;
    logic [1:0]      r_sel;
    logic [1:0]      r_rr_ptr;
    logic [LW-1:0]   r_len_q;
    logic [LW-1:0]   r_cnt;

    logic            w_found;
    logic [1:0]      w_pick;
    logic [LW-1:0]   w_pick_len;
    logic            w_len_bad;
    logic            w_space_ok;
    logic            w_xfer;
    logic            w_wr_en;
    logic            w_last;
    logic [3:0]      w_sel_oh;

    // Round-robin scan: walking from the farthest offset down to offset 0
    // leaves the first requester at or after r_rr_ptr in w_pick.
    always_comb begin
        w_pick = r_rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (i_req[r_rr_ptr + 2'(k)]) begin
                w_pick = r_rr_ptr + 2'(k);
            end
        end
    end

    assign w_found    = |i_req;
    assign w_pick_len = i_req_len[int'(w_pick)*LW +: LW];
    assign w_len_bad  = (r_len_q == '0) || (32'(r_len_q) > DP);
    // Free space only grows between samples, so this reservation is safe.
    assign w_space_ok = CW'(i_fifo_free) >= CW'(r_len_q);
    assign w_xfer     = (r_state == StXfer);
    assign w_sel_oh   = 4'b0001 << r_sel;
    // The full gate is a defensive stall; a correct reservation never hits it.
    assign w_wr_en    = w_xfer && !i_fifo_full;
    assign w_last     = w_wr_en && (r_cnt == LW'(1));

    assign o_fifo_wr_en   = w_wr_en;
    assign o_gnt          = w_xfer ? w_sel_oh : 4'b0000;
    assign o_data_ack     = o_gnt & {4{w_wr_en}};
    assign o_burst_done   = w_last ? w_sel_oh : 4'b0000;
    assign o_req_err      = ((r_state == StWait) && w_len_bad) ? w_sel_oh : 4'b0000;
    assign o_busy         = (r_state != StIdle);
    assign o_fifo_wr_data = i_req_data[int'(r_sel)*W +: W];

    always_ff @(posedge wr_clk or negedge wr_reset_n) begin
        if (!wr_reset_n) begin
            r_state  <= StIdle;
            r_sel    <= 2'd0;
            r_rr_ptr <= 2'd0;
            r_len_q  <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_sel   <= w_pick;
                        r_len_q <= w_pick_len;
                        r_cnt   <= w_pick_len;
                        r_state <= StWait;
                    end
                end
                StWait: begin
                    if (w_len_bad) begin
                        r_rr_ptr <= r_sel + 2'd1;
                        r_state  <= StIdle;
                    end else if (!i_req[r_sel]) begin
                        // Withdrawn before admission: no error, pointer kept.
                        r_state <= StIdle;
                    end else if (w_space_ok) begin
                        r_state <= StXfer;
                    end
                    // Otherwise hold: head-of-line wait, no skipping.
                end
                StXfer: begin
                    if (w_wr_en) begin
                        r_cnt <= r_cnt - LW'(1);
                        if (w_last) begin
                            r_rr_ptr <= r_sel + 2'd1;
                            r_state  <= StIdle;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_async_fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// tb_async_fifo_wr_arb
// Self-checking bench for async_fifo_wr_arb: a table of single-request vectors,
// hand-written multi-cycle sequences, and a randomized run scored against a
// burst-level reference model.
// -----------------------------------------------------------------------------
module tb_async_fifo_wr_arb;

    localparam int W  = 8;
    localparam int DP = 16;
    localparam int AW = 4;
    localparam int LW = 5;

    logic            wr_clk = 1'b0;
    logic            wr_reset_n;
    logic [3:0]      req;
    logic [4*LW-1:0] req_len;
    logic [4*W-1:0]  req_data;
    logic [3:0]      gnt;
    logic [3:0]      data_ack;
    logic [3:0]      burst_done;
    logic [3:0]      req_err;
    logic            fifo_wr_en;
    logic [W-1:0]    fifo_wr_data;
    logic [AW:0]     fifo_free;
    logic            fifo_full;
    logic            busy;

    async_fifo_wr_arb #(.W(W), .DP(DP), .AW(AW), .LW(LW)) dut (
        .wr_clk         (wr_clk),
        .wr_reset_n     (wr_reset_n),
        .i_req          (req),
        .i_req_len      (req_len),
        .i_req_data     (req_data),
        .o_gnt          (gnt),
        .o_data_ack     (data_ack),
        .o_burst_done   (burst_done),
        .o_req_err      (req_err),
        .o_fifo_wr_en   (fifo_wr_en),
        .o_fifo_wr_data (fifo_wr_data),
        .i_fifo_free    (fifo_free),
        .i_fifo_full    (fifo_full),
        .o_busy         (busy)
    );

    always #5 wr_clk = ~wr_clk;

    int total = 0;
    int bad   = 0;

    // Per-requester word pointer; the requester shows {id, pointer} as its word.
    logic [5:0] wptr [4];

    typedef struct {
        int         r;
        int         len;
        int         free;
        bit         full;
        logic [3:0] err1;
        logic [3:0] gnt2;
        bit         wr2;
        bit         busy2;
    } vec_t;

    vec_t vt [9];

    // Reference model state (burst level)
    int         m_ph;   // 0 nothing chosen, 1 chosen awaiting admission, 2 streaming
    int         m_sel;
    int         m_len;
    int         m_cnt;
    int         m_rr;
    int         m_tot [4];
    logic [3:0] oh, e_gnt, e_err, e_done, e_ack;
    logic       e_wr, e_busy, illegal;
    logic [3:0] obs_done, obs_err, obs_gnt;
    int         nwr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_len(input int i, input int l);
        req_len[i*LW +: LW] = LW'(l);
    endtask

    task automatic update_data();
        for (int i = 0; i < 4; i++) req_data[i*W +: W] = {2'(i), wptr[i]};
    endtask

    // Advance one clock; requesters step their word on an acknowledged edge.
    task automatic adv();
        logic [3:0] ack;
        ack = data_ack;
        @(posedge wr_clk);
        #1;
        for (int i = 0; i < 4; i++) if (ack[i]) wptr[i] = wptr[i] + 6'd1;
        update_data();
    endtask

    task automatic do_reset();
        wr_reset_n = 1'b0;
        req        = 4'b0000;
        req_len    = '0;
        fifo_free  = '0;
        fifo_full  = 1'b0;
        for (int i = 0; i < 4; i++) wptr[i] = 6'd0;
        update_data();
        #1;
        chk("reset_outs", 32'({busy, gnt, data_ack, burst_done, req_err, fifo_wr_en}), 32'd0);
        @(posedge wr_clk);
        #1;
        wr_reset_n = 1'b1;
    endtask

    function automatic int rand_len();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 0;
        if (r == 1) return int'($urandom_range(17, 31));
        return int'($urandom_range(1, 16));
    endfunction

    initial begin
        // ---------------- table-driven single-request vectors ----------------
        vt[0] = '{0, 4,  16, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b1};
        vt[1] = '{1, 0,  16, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0};
        vt[2] = '{2, 17, 16, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0};
        vt[3] = '{3, 16, 16, 1'b0, 4'b0000, 4'b1000, 1'b1, 1'b1};
        vt[4] = '{0, 16, 15, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1};
        vt[5] = '{1, 5,  5,  1'b1, 4'b0000, 4'b0010, 1'b0, 1'b1};
        vt[6] = '{2, 31, 31, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0};
        vt[7] = '{3, 1,  1,  1'b0, 4'b0000, 4'b1000, 1'b1, 1'b1};
        vt[8] = '{0, 2,  0,  1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1};

        for (int v = 0; v < 9; v++) begin
            do_reset();
            set_len(vt[v].r, vt[v].len);
            fifo_free     = 5'(vt[v].free);
            fifo_full     = vt[v].full;
            req[vt[v].r]  = 1'b1;
            #1;
            chk("vec_busy0", 32'(busy), 32'd0);
            adv();
            #1;
            chk("vec_err1", 32'(req_err), 32'(vt[v].err1));
            chk("vec_busy1", 32'(busy), 32'd1);
            chk("vec_gnt1", 32'(gnt), 32'd0);
            adv();
            #1;
            chk("vec_gnt2", 32'(gnt), 32'(vt[v].gnt2));
            chk("vec_wr2", 32'(fifo_wr_en), 32'(vt[v].wr2));
            chk("vec_busy2", 32'(busy), 32'(vt[v].busy2));
        end

        // ---------------- single burst, then pointer moves past 2 ------------
        do_reset();
        set_len(2, 4);
        fifo_free = 5'd16;
        req       = 4'b0100;
        for (int k = 0; k <= 8; k++) begin
            logic ew;
            ew = (k >= 2 && k <= 5) || (k == 8);
            #1;
            chk("one_wr", 32'(fifo_wr_en), 32'(ew));
            chk("one_done", 32'(burst_done), (k == 5) ? 32'h4 : 32'h0);
            if (k >= 2 && k <= 5) begin
                chk("one_ack", 32'(data_ack), 32'h4);
                chk("one_data", 32'(fifo_wr_data), 32'({2'd2, 6'(k - 2)}));
            end
            if (k == 8) chk("rr_after_2", 32'(gnt), 32'h8);
            if (k == 5) begin
                req = 4'b1001;
                set_len(0, 2);
                set_len(3, 2);
            end
            adv();
        end

        // ---------------- all four requesting: strict round robin -------------
        do_reset();
        for (int i = 0; i < 4; i++) set_len(i, 3);
        fifo_free = 5'd16;
        req       = 4'b1111;
        nwr       = 0;
        for (int k = 0; k < 25; k++) begin
            #1;
            chk("rr_gnt", 32'(gnt), (k % 5 >= 2) ? 32'(4'b0001 << ((k / 5) % 4)) : 32'd0);
            if (fifo_wr_en) nwr++;
            adv();
        end
        chk("rr_writes", 32'(nwr), 32'd15);

        // ---------------- head-of-line hold until space appears ---------------
        do_reset();
        set_len(1, 10);
        set_len(2, 3);
        fifo_free = 5'd6;
        req       = 4'b0110;
        for (int k = 0; k <= 20; k++) begin
            #1;
            if (k >= 1 && k <= 7) chk("hold_busy", 32'(busy), 32'd1);
            chk("hold_gnt", 32'(gnt),
                (k >= 8 && k <= 17) ? 32'h2 : (k == 20) ? 32'h4 : 32'h0);
            if (k >= 8 && k <= 17)
                chk("hold_data", 32'(fifo_wr_data), 32'({2'd1, 6'(k - 8)}));
            if (k == 7) fifo_free = 5'd10;
            adv();
        end

        // ---------------- illegal lengths 0 and 20 ----------------------------
        do_reset();
        set_len(0, 0);
        set_len(1, 2);
        fifo_free = 5'd16;
        req       = 4'b0011;
        for (int k = 0; k <= 11; k++) begin
            logic ew;
            ew = (k == 4) || (k == 5) || (k == 10) || (k == 11);
            #1;
            chk("err_pulse", 32'(req_err), (k == 1 || k == 7) ? 32'h1 : 32'h0);
            chk("err_wr", 32'(fifo_wr_en), 32'(ew));
            chk("err_gnt", 32'(gnt), ew ? 32'h2 : 32'h0);
            if (k == 1) set_len(0, 20);
            adv();
        end

        // ---------------- full stall mid-burst --------------------------------
        do_reset();
        set_len(0, 5);
        fifo_free = 5'd16;
        req       = 4'b0001;
        nwr       = 0;
        for (int k = 0; k <= 9; k++) begin
            logic ew;
            fifo_full = (k == 3) || (k == 4);
            ew = (k == 2) || (k >= 5 && k <= 8);
            #1;
            chk("stall_wr", 32'(fifo_wr_en), 32'(ew));
            chk("stall_ack", 32'(data_ack), ew ? 32'h1 : 32'h0);
            chk("stall_done", 32'(burst_done), (k == 8) ? 32'h1 : 32'h0);
            if (fifo_wr_en) begin
                chk("stall_data", 32'(fifo_wr_data), 32'({2'd0, 6'(nwr)}));
                nwr++;
            end
            adv();
        end
        fifo_full = 1'b0;
        chk("stall_count", 32'(nwr), 32'd5);

        // ---------------- reset mid-burst -------------------------------------
        do_reset();
        set_len(2, 1);
        set_len(1, 6);
        fifo_free = 5'd16;
        req       = 4'b0100;
        for (int k = 0; k <= 6; k++) begin
            #1;
            if (k == 2 || k == 5 || k == 6) begin
                chk("mid_wr", 32'(fifo_wr_en), 32'd1);
                chk("mid_gnt", 32'(gnt), (k == 2) ? 32'h4 : 32'h2);
            end
            if (k == 2) req = 4'b0010;
            adv();
        end
        wr_reset_n = 1'b0;
        #1;
        chk("mid_rst_outs", 32'({busy, gnt, data_ack, burst_done, req_err, fifo_wr_en}), 32'd0);
        adv();
        req = 4'b1111;
        for (int i = 0; i < 4; i++) set_len(i, 2);
        wr_reset_n = 1'b1;
        #1;
        chk("post_rst_busy", 32'(busy), 32'd0);
        adv();
        #1;
        chk("post_rst_wait", 32'({busy, gnt}), 32'h10);
        adv();
        #1;
        chk("post_rst_gnt0", 32'(gnt), 32'h1);

        // ---------------- randomized run vs. burst-level model ----------------
        do_reset();
        m_ph = 0; m_sel = 0; m_len = 0; m_cnt = 0; m_rr = 0;
        for (int i = 0; i < 4; i++) begin
            m_tot[i] = 0;
            set_len(i, rand_len());
        end
        req = 4'b1111;
        for (int c = 0; c < 3000; c++) begin
            fifo_free = 5'($urandom_range(0, 20));
            fifo_full = ($urandom_range(0, 9) == 0);
            #1;
            oh      = 4'(1 << m_sel);
            illegal = (m_len == 0) || (m_len > DP);
            e_busy  = (m_ph != 0);
            e_gnt   = (m_ph == 2) ? oh : 4'b0000;
            e_wr    = (m_ph == 2) && !fifo_full;
            e_ack   = e_wr ? e_gnt : 4'b0000;
            e_err   = (m_ph == 1 && illegal) ? oh : 4'b0000;
            e_done  = (e_wr && (m_cnt + 1 == m_len)) ? oh : 4'b0000;
            chk("rnd_ctl", 32'({busy, gnt, data_ack, burst_done, req_err, fifo_wr_en}),
                32'({e_busy, e_gnt, e_ack, e_done, e_err, e_wr}));
            if (e_wr)
                chk("rnd_data", 32'(fifo_wr_data), 32'({2'(m_sel), 6'(m_tot[m_sel])}));
            obs_done = burst_done;
            obs_err  = req_err;
            obs_gnt  = gnt;
            // Model advance
            if (m_ph == 0) begin
                for (int k = 3; k >= 0; k--) begin
                    if (req[(m_rr + k) % 4]) begin
                        m_sel = (m_rr + k) % 4;
                        m_ph  = 1;
                    end
                end
                if (m_ph == 1) m_len = int'(req_len[m_sel*LW +: LW]);
            end else if (m_ph == 1) begin
                if (illegal) begin
                    m_rr = (m_sel + 1) % 4;
                    m_ph = 0;
                end else if (!req[m_sel]) begin
                    m_ph = 0;
                end else if (int'(fifo_free) >= m_len) begin
                    m_ph  = 2;
                    m_cnt = 0;
                end
            end else if (e_wr) begin
                m_cnt++;
                m_tot[m_sel]++;
                if (m_cnt == m_len) begin
                    m_rr = (m_sel + 1) % 4;
                    m_ph = 0;
                end
            end
            adv();
            // Requester behaviour: new burst after completion/rejection,
            // occasionally raise or drop a request that is not being served.
            for (int i = 0; i < 4; i++) begin
                if (obs_done[i] || obs_err[i]) set_len(i, rand_len());
                else if (!obs_gnt[i] && $urandom_range(0, 15) == 0) req[i] = ~req[i];
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
